// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkt_ctrl
// Purpose  : SYNC/LEN/payload packet framer behind a UART receiver, with a
//            host-read packet buffer, error reporting and drop accounting.
//            Optional checksum byte enabled by UART_RX_PKT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 4096
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [7:0]                                     rx_data,
    input  logic                                           rx_ready,
    output logic                                           pkt_valid,
    output logic [$clog2(MAX_LEN+1)-1:0]                   pkt_len,
    input  logic [(MAX_LEN > 1 ? $clog2(MAX_LEN) : 1)-1:0] rd_addr,
    output logic [7:0]                                     rd_data,
    input  logic                                           pkt_ack,
    output logic                                           err,
    output logic [1:0]                                     err_code,
    output logic [7:0]                                     drop_cnt,
    output logic                                           busy
);

    localparam int PW    = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [7:0]    c_max_len = 8'(MAX_LEN);
    localparam logic [PW-1:0] c_one     = PW'(1);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef UART_RX_PKT_CHECKSUM_EN
        S_CHK     = 3'd3,
`endif
        S_HOLD    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rdy_q;
    logic          w_strobe;
    logic          w_tmo;
    logic          w_busy;

    logic          w_err;
    logic [1:0]    w_err_code;
    logic          w_len_ld;
    logic          w_buf_wr;
    logic          w_drop;

    logic [PW-1:0] r_pkt_len;
    logic [PW-1:0] r_idx;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic [7:0]    r_drop_cnt;
    logic [7:0]    r_rd_data;
    logic [7:0]    r_buf [DEPTH];

`ifdef UART_RX_PKT_CHECKSUM_EN
    logic [7:0]    r_sum;
    logic          w_sum_ok;

    assign w_sum_ok = ((r_sum + rx_data) == 8'd0);
    assign w_busy   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
`else
    assign w_busy   = (r_state == S_LEN) || (r_state == S_PAYLOAD);
`endif

    // rdy_q powers up high so a level already asserted at reset release is not a new byte
    assign w_strobe = rx_ready & ~r_rdy_q;

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
            logic [TW-1:0]            r_tmo_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tmo_cnt <= '0;
                end else if (!w_busy || w_strobe) begin
                    r_tmo_cnt <= '0;
                end else if (r_tmo_cnt != c_tmo_last) begin
                    r_tmo_cnt <= r_tmo_cnt + TW'(1);
                end
            end

            assign w_tmo = w_busy && !w_strobe && (r_tmo_cnt == c_tmo_last);
        end else begin : g_no_tmo
            assign w_tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = 2'd0;
        w_len_ld    = 1'b0;
        w_buf_wr    = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (w_strobe && (rx_data == SYNC)) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_tmo) begin
                    w_err       = 1'b1;
                    w_err_code  = 2'd3;
                    w_state_nxt = S_HUNT;
                end else if (w_strobe) begin
                    if ((rx_data == 8'd0) || (rx_data > c_max_len)) begin
                        w_err       = 1'b1;
                        w_err_code  = 2'd1;
                        w_state_nxt = S_HUNT;
                    end else begin
                        w_len_ld    = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_tmo) begin
                    w_err       = 1'b1;
                    w_err_code  = 2'd3;
                    w_state_nxt = S_HUNT;
                end else if (w_strobe) begin
                    w_buf_wr = 1'b1;
                    if (r_idx == (r_pkt_len - c_one)) begin
`ifdef UART_RX_PKT_CHECKSUM_EN
                        w_state_nxt = S_CHK;
`else
                        w_state_nxt = S_HOLD;
`endif
                    end
                end
            end
`ifdef UART_RX_PKT_CHECKSUM_EN
            S_CHK: begin
                if (w_tmo) begin
                    w_err       = 1'b1;
                    w_err_code  = 2'd3;
                    w_state_nxt = S_HUNT;
                end else if (w_strobe) begin
                    if (w_sum_ok) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = 2'd2;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
`endif
            S_HOLD: begin
                // a byte arriving with the ack is still counted; ack releases regardless
                w_drop = w_strobe;
                if (pkt_ack) begin
                    w_state_nxt = S_HUNT;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_q    <= 1'b1;
            r_pkt_len  <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_rdy_q <= rx_ready;
            r_err   <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if (w_len_ld) begin
                r_pkt_len <= rx_data[PW-1:0];
                r_idx     <= '0;
            end else if (w_buf_wr) begin
                r_idx <= r_idx + c_one;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

`ifdef UART_RX_PKT_CHECKSUM_EN
    // LEN seeds the running sum so the checksum covers LEN + payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= 8'd0;
        end else if (w_len_ld) begin
            r_sum <= rx_data;
        end else if (w_buf_wr) begin
            r_sum <= r_sum + rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_buf[r_idx[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'd0;
        end else begin
            r_rd_data <= r_buf[rd_addr];
        end
    end

    assign pkt_valid = (r_state == S_HOLD);
    assign busy      = w_busy;
    assign pkt_len   = r_pkt_len;
    assign rd_data   = r_rd_data;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_pkt_ctrl
// Purpose  : Scoreboard bench for uart_rx_pkt_ctrl (MAX_LEN=16, TIMEOUT=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

    localparam int K_ERR   = 0;
    localparam int K_PKT   = 1;
    localparam int K_RD    = 2;
    localparam int K_DROP  = 3;
    localparam int K_VALID = 4;
    localparam int K_BUSY  = 5;
    localparam int K_CODE  = 6;
    localparam int K_LEN   = 7;

    typedef struct {
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       pkt_valid;
    logic [4:0] pkt_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       pkt_ack;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;
    logic       busy;

    exp_t       sb_q[$];
    int         n_vec;
    int         n_bad;
    logic       probe;
    int         probe_kind;
    logic       valid_q;
    logic [7:0] pay [16];

    uart_rx_pkt_ctrl #(
        .MAX_LEN (16),
        .SYNC    (8'hA5),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .pkt_valid (pkt_valid),
        .pkt_len   (pkt_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pkt_ack   (pkt_ack),
        .err       (err),
        .err_code  (err_code),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sample(input int k);
        case (k)
            K_RD:    return rd_data;
            K_DROP:  return drop_cnt;
            K_VALID: return {7'd0, pkt_valid};
            K_BUSY:  return {7'd0, busy};
            K_CODE:  return {6'd0, err_code};
            K_LEN:   return {3'd0, pkt_len};
            default: return 8'd0;
        endcase
    endfunction

    task automatic check_evt(input int kind, input logic [7:0] act);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected event kind=%0d actual=%02h (nothing expected)", kind, act);
        end else begin
            e = sb_q.pop_front();
            if ((e.kind != kind) || (e.val !== act)) begin
                n_bad++;
                $display("FAIL %s: kind=%0d actual=%02h, expected kind=%0d value=%02h",
                         e.name, kind, act, e.kind, e.val);
            end
        end
    endtask

    // monitor: spontaneous err/packet events plus explicit probes, all in order
    initial valid_q = 1'b0;
    always @(negedge clk) begin
        if (err) check_evt(K_ERR, {6'd0, err_code});
        if (pkt_valid && !valid_q) check_evt(K_PKT, {3'd0, pkt_len});
        valid_q = pkt_valid;
        if (probe) check_evt(probe_kind, sample(probe_kind));
    end

    task automatic expect_evt(input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_probe(input int kind, input logic [7:0] v, input string nm);
        expect_evt(kind, v, nm);
        probe_kind = kind;
        probe      = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] v);
        rd_addr = a;
        tick(1);
        do_probe(K_RD, v, "rd_data");
    endtask

    task automatic ack_pulse();
        pkt_ack = 1'b1;
        tick(1);
        pkt_ack = 1'b0;
        tick(1);
    endtask

    // SYNC, LEN, pay[0..len-1] and, when enabled, the checksum offset by bad
    task automatic send_pkt(input int len, input logic [7:0] bad);
        logic [7:0] s;
        s = 8'(len);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            send_byte(pay[i]);
            s = s + pay[i];
        end
`ifdef UART_RX_PKT_CHECKSUM_EN
        send_byte(8'(8'd0 - s) + bad);
`else
        if (bad != 8'd0) s = 8'd0;
`endif
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        probe      = 1'b0;
        probe_kind = 0;
        rst_n      = 1'b0;
        rx_data    = 8'hA5;
        rx_ready   = 1'b1;
        rd_addr    = 4'd0;
        pkt_ack    = 1'b0;
        tick(2);

        // reset values, with rx_ready already high
        do_probe(K_VALID, 8'd0, "reset pkt_valid");
        do_probe(K_LEN,   8'd0, "reset pkt_len");
        do_probe(K_RD,    8'd0, "reset rd_data");
        do_probe(K_CODE,  8'd0, "reset err_code");
        do_probe(K_DROP,  8'd0, "reset drop_cnt");
        do_probe(K_BUSY,  8'd0, "reset busy");
        rst_n = 1'b1;
        tick(4);
        do_probe(K_BUSY, 8'd0, "no strobe at reset release");
        rx_ready = 1'b0;
        tick(2);

        // basic packet
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        expect_evt(K_PKT, 8'd3, "pkt3 len");
        send_pkt(3, 8'd0);
        tick(2);
        do_probe(K_LEN, 8'd3, "pkt_len 3");
        read_chk(4'd0, 8'h01);
        read_chk(4'd1, 8'h02);
        read_chk(4'd2, 8'h03);
        do_probe(K_VALID, 8'd1, "valid held");
        ack_pulse();
        do_probe(K_VALID, 8'd0, "valid after ack");

`ifdef UART_RX_PKT_CHECKSUM_EN
        expect_evt(K_ERR, 8'd2, "bad checksum");
        send_pkt(3, 8'hFF);
        tick(2);
        do_probe(K_VALID, 8'd0, "no valid on bad chk");
        do_probe(K_CODE, 8'd2, "err_code 2");
`endif

        // ack outside HOLD is ignored mid-packet
        expect_evt(K_PKT, 8'd1, "pkt1 len");
        send_byte(8'hA5);
        send_byte(8'h01);
        ack_pulse();
        send_byte(8'h7E);
`ifdef UART_RX_PKT_CHECKSUM_EN
        send_byte(8'h81);
`endif
        tick(2);
        read_chk(4'd0, 8'h7E);
        ack_pulse();

        // LEN bounds
        expect_evt(K_ERR, 8'd1, "len 0");
        send_byte(8'hA5);
        send_byte(8'h00);
        expect_evt(K_ERR, 8'd1, "len 17");
        send_byte(8'hA5);
        send_byte(8'h11);
        tick(2);
        do_probe(K_CODE, 8'd1, "err_code 1");
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h10 + i);
        expect_evt(K_PKT, 8'd16, "pkt16 len");
        send_pkt(16, 8'd0);
        tick(2);
        do_probe(K_LEN, 8'd16, "pkt_len 16");
        read_chk(4'd15, 8'h1F);
        read_chk(4'd0, 8'h10);
        ack_pulse();

        // inter-byte timeout
        expect_evt(K_ERR, 8'd3, "timeout");
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        tick(70);
        do_probe(K_BUSY, 8'd0, "busy after timeout");
        do_probe(K_CODE, 8'd3, "err_code 3");
        pay[0] = 8'hC3; pay[1] = 8'h3C;
        expect_evt(K_PKT, 8'd2, "pkt2 after timeout");
        send_pkt(2, 8'd0);
        tick(2);
        read_chk(4'd1, 8'h3C);

        // drops while held; ack together with a strobe
        send_byte(8'h55);
        send_byte(8'hAA);
        do_probe(K_DROP, 8'd2, "drop 2");
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        pkt_ack  = 1'b1;
        tick(1);
        pkt_ack  = 1'b0;
        rx_ready = 1'b0;
        tick(1);
        do_probe(K_VALID, 8'd0, "valid after ack+strobe");
        do_probe(K_BUSY,  8'd0, "hunt after ack+strobe");
        do_probe(K_DROP,  8'd3, "drop counts ack byte");

        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        expect_evt(K_PKT, 8'd4, "pkt4 len");
        send_pkt(4, 8'd0);
        for (int i = 0; i < 300; i++) send_byte(8'(i));
        do_probe(K_DROP, 8'd255, "drop saturates");
        read_chk(4'd0, 8'hDE);
        read_chk(4'd1, 8'hAD);
        read_chk(4'd2, 8'hBE);
        read_chk(4'd3, 8'hEF);
        do_probe(K_VALID, 8'd1, "still held");
        ack_pulse();

        // reset mid-packet
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        do_probe(K_BUSY, 8'd1, "busy mid-packet");
        rst_n = 1'b0;
        #1;
        do_probe(K_BUSY,  8'd0, "abort busy");
        do_probe(K_VALID, 8'd0, "abort pkt_valid");
        do_probe(K_LEN,   8'd0, "abort pkt_len");
        do_probe(K_CODE,  8'd0, "abort err_code");
        do_probe(K_DROP,  8'd0, "abort drop_cnt");
        rst_n = 1'b1;
        tick(2);
        pay[0] = 8'h11; pay[1] = 8'h22;
        expect_evt(K_PKT, 8'd2, "pkt after reset");
        send_pkt(2, 8'd0);
        tick(2);
        read_chk(4'd1, 8'h22);
        read_chk(4'd0, 8'h11);
        ack_pulse();
        do_probe(K_VALID, 8'd0, "final valid");

        tick(5);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: event never seen, expected value=%02h", e.name, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
